row_clear_engine: RTL

- Tetris line-clear engine; sits directly upstream of the board RAM and drives its single port (addr, wEn, dataIn), consuming its registered dataOut.
- Board layout: one word per row at BASE_ADDR+r; r=0 is the top row, r=ROWS-1 the bottom; bits [COLS-1:0] are cell occupancy.
- On a start pulse the engine scans bottom to top, deletes every full row, shifts the rows above it down, and reports the number of lines cleared.

---
 rtl/row_clear_engine_if.sv | 26 ++
 rtl/row_clear_engine.sv | 134 +++++++++++++
 2 files changed

// File: rtl/row_clear_engine_if.sv
// Bundle for the line-clear engine: control handshake to the game logic plus
// the single-port board RAM bus. The engine connects to the slave modport.
interface row_clear_engine_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int CNT_WIDTH     = 5
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [CNT_WIDTH-1:0]     lines_cleared;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic                     ram_wEn;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;

    modport master (
        output start, ram_dataOut,
        input  busy, done, lines_cleared, ram_addr, ram_wEn, ram_dataIn
    );

    modport slave (
        input  start, ram_dataOut,
        output busy, done, lines_cleared, ram_addr, ram_wEn, ram_dataIn
    );
endinterface

// File: rtl/row_clear_engine.sv
// Tetris line-clear engine: scans the board bottom to top, deletes full rows by
// shifting everything above down one word, and reports how many lines went.
//
// state | meaning
// IDLE  | waiting for start
// READ  | present row r to the RAM
// EVAL  | test row r for full occupancy
// SH_RD | read row k-1
// SH_WR | write that word into row k
// ZERO  | clear row 0, count the line, re-check row r
// DONE  | one-cycle done pulse, then back to IDLE
module row_clear_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int ROWS          = 20,
    parameter int COLS          = 10,
    parameter int BASE_ADDR     = 0,
    parameter int CNT_WIDTH     = 5
) (
    input logic               clk,
    input logic               rst_n,
    row_clear_engine_if.slave bus
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE, READ, EVAL, SH_RD, SH_WR, ZERO, DONE
    } state_t;

    state_t                   r_state;
    logic [ROW_W-1:0]         r_row;
    logic [ROW_W-1:0]         r_k;
    logic [CNT_WIDTH-1:0]     r_count;
    logic [CNT_WIDTH-1:0]     r_lines;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_full;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic                     w_wen;
    logic [DATA_WIDTH-1:0]    w_din;

    assign w_full = &bus.ram_dataOut[COLS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_k     <= '0;
            r_count <= '0;
            r_lines <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_row   <= ROW_W'(ROWS - 1);
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: r_state <= EVAL;
                EVAL: begin
                    if (w_full) begin
                        // Nothing above row 0 to pull down, so skip the shift loop.
                        if (r_row == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_k     <= r_row;
                            r_state <= SH_RD;
                        end
                    end else if (r_row == '0) begin
                        r_lines <= r_count;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_row   <= r_row - ROW_W'(1);
                        r_state <= READ;
                    end
                end
                SH_RD: r_state <= (r_k == '0) ? ZERO : SH_WR;
                SH_WR: begin
                    r_k     <= r_k - ROW_W'(1);
                    r_state <= (r_k == ROW_W'(1)) ? ZERO : SH_RD;
                end
                ZERO: begin
                    r_count <= r_count + CNT_WIDTH'(1);
                    r_state <= READ;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_addr = BASE;
        w_wen  = 1'b0;
        w_din  = '0;
        case (r_state)
            READ:  w_addr = BASE + ADDRESS_WIDTH'(r_row);
            SH_RD: begin
                if (r_k != '0) begin
                    w_addr = BASE + ADDRESS_WIDTH'(r_k - ROW_W'(1));
                end
            end
            SH_WR: begin
                // Whole word moves, including bits above the occupancy field.
                w_addr = BASE + ADDRESS_WIDTH'(r_k);
                w_wen  = 1'b1;
                w_din  = bus.ram_dataOut;
            end
            ZERO: begin
                w_addr = BASE;
                w_wen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.lines_cleared = r_lines;
    assign bus.ram_addr      = w_addr;
    assign bus.ram_wEn       = w_wen;
    assign bus.ram_dataIn    = w_din;
endmodule
